// File: rtl/sync_debounce.sv
// Multi-channel synchronizer and debouncer with optional rise/fall pulse outputs.
// Define SYNC_DEBOUNCE_EDGE_EN to build the rise/fall edge registers.

module sync_debounce_lane #(
  parameter int   STAGES       = 2,
  parameter int   DEBOUNCE_CNT = 16,
  parameter int   CW           = 5,
  parameter logic RST_BIT      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              s, flip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {STAGES{RST_BIT}};
    else       sync_q <= {sync_q[STAGES-2:0], din_i};
  end

  assign s = sync_q[STAGES-1];

  // Change is accepted on the edge that completes DEBOUNCE_CNT disagreeing samples.
  always_comb begin
    flip   = (s != dout_q) && (cnt_q == LAST);
    dout_d = flip ? s : dout_q;
    cnt_d  = cnt_q + 1'b1;
    if (s == dout_q || flip) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dout_q <= RST_BIT;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= flip & s;
      fall_q <= flip & ~s;
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

  assign dout_o = dout_q;
  assign busy_o = |cnt_q;
endmodule

module sync_debounce #(
  parameter int               WIDTH        = 4,
  parameter int               STAGES       = 2,
  parameter int               DEBOUNCE_CNT = 16,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             busy
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_debounce: WIDTH %0d outside 1..32", WIDTH);
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_debounce: STAGES %0d outside 2..4", STAGES);
  end
  if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 65535) begin : g_bad_cnt
    $error("sync_debounce: DEBOUNCE_CNT %0d outside 1..65535", DEBOUNCE_CNT);
  end

  logic [WIDTH-1:0] lane_busy;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sync_debounce_lane #(
      .STAGES      (STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CW          (CW),
      .RST_BIT     (RESET_VAL[i])
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .din_i (din[i]),
      .dout_o(dout[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i]),
      .busy_o(lane_busy[i])
    );
  end

  assign busy = |lane_busy;
endmodule

// File: tb/tb_sync_debounce.sv
// Randomized bench for sync_debounce: history-window reference model plus directed literal checks.
module tb_sync_debounce;
  localparam int W = 4, ST = 2, CNT = 4;
  localparam logic [W-1:0] RV = 4'hF;

  logic clk = 1'b0, reset = 1'b0;
  logic [W-1:0] din = RV;
  logic [W-1:0] dout, rise, fall, dout_b, rise_b, fall_b;
  logic busy, busy_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sync_debounce #(.WIDTH(W), .STAGES(ST), .DEBOUNCE_CNT(CNT), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .rise(rise), .fall(fall), .busy(busy));
  sync_debounce #(.WIDTH(W), .STAGES(ST), .DEBOUNCE_CNT(1), .RESET_VAL(RV)) dut_b (
    .clk(clk), .reset(reset), .din(din), .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] edge_exp(input logic [W-1:0] v);
`ifdef SYNC_DEBOUNCE_EDGE_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Reference: an output flips when the last CNT samples seen by the debouncer all disagree with it.
  logic [W-1:0] m_pipe [ST];
  logic [W-1:0] m_win  [CNT];
  logic [W-1:0] b_hist [4];
  logic [W-1:0] m_dout, m_rise, m_fall, s_pre, flip;
  logic         m_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_pipe[k]) m_pipe[k] = RV;
      foreach (m_win[k])  m_win[k]  = RV;
      foreach (b_hist[k]) b_hist[k] = RV;
      m_dout = RV; m_rise = '0; m_fall = '0; m_busy = 1'b0;
    end else begin
      s_pre = m_pipe[ST-1];
      for (int k = CNT-1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = s_pre;
      flip = '1;
      foreach (m_win[k]) flip &= (m_win[k] ^ m_dout);
      m_busy = |((s_pre ^ m_dout) & ~flip);
      m_rise = flip & ~m_dout;
      m_fall = flip & m_dout;
      m_dout = m_dout ^ flip;
      for (int k = ST-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = din;
      for (int k = 3; k > 0; k--) b_hist[k] = b_hist[k-1];
      b_hist[0] = din;
    end
  end

  always @(posedge clk) begin
    #3;
    check("dout", dout, m_dout);
    check("rise", rise, edge_exp(m_rise));
    check("fall", fall, edge_exp(m_fall));
    check("busy", busy, m_busy);
    check("rise_and_fall", rise & fall, '0);
    check("cnt1_dout", dout_b, b_hist[2]);
    check("cnt1_rise", rise_b, edge_exp(b_hist[2] & ~b_hist[3]));
    check("cnt1_fall", fall_b, edge_exp(~b_hist[2] & b_hist[3]));
    check("cnt1_busy", busy_b, 1'b0);
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [W-1:0] acc;
  int hold;

  initial begin
    reset = 1'b1; din = RV;
    edges(2);
    check("rst_dout", dout, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_fall", fall, 4'h0);
    reset = 1'b0;
    edges(3);

    // Channel 0 goes low and stays low.
    din = 4'hE;
    for (int k = 0; k < 8; k++) begin
      edges(1);
      check("r030_dout", dout, (k >= 5) ? 4'hE : 4'hF);
      check("r030_fall", fall, (k == 5) ? edge_exp(4'h1) : 4'h0);
      check("r030_busy", busy, (k >= 2 && k <= 4));
    end

    din = 4'hF; edges(8);
    check("settle_dout", dout, 4'hF);

    // Three-cycle glitch must be rejected.
    acc = '0;
    din = 4'hE; edges(3);
    acc |= fall;
    din = 4'hF;
    for (int k = 0; k < 7; k++) begin edges(1); acc |= fall; end
    check("r031_dout", dout, 4'hF);
    check("r031_fall", acc, 4'h0);
    check("r031_busy", busy, 1'b0);

    // Multi-channel simultaneous change.
    din = 4'h6;
    for (int k = 0; k < 8; k++) begin
      edges(1);
      check("r032_dout", dout, (k >= 5) ? 4'h6 : 4'hF);
      check("r032_fall", fall, (k == 5) ? edge_exp(4'h9) : 4'h0);
    end
    din = 4'hF;
    for (int k = 0; k < 8; k++) begin
      edges(1);
      check("r032_rise", rise, (k == 5) ? edge_exp(4'h9) : 4'h0);
    end

    // Reset mid-count aborts the pending change.
    din = 4'hE; edges(5);
    reset = 1'b1; #1;
    check("r033_dout", dout, 4'hF);
    check("r033_busy", busy, 1'b0);
    edges(1);
    check("r033_fall", fall, 4'h0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edges(1);
      check("r033_after", dout, (k >= 5) ? 4'hE : 4'hF);
    end

    // Random bursts around the debounce threshold, occasional resets.
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1; edges(1); reset = 1'b0;
      end
      if ($urandom_range(0, 3) != 0) din = din ^ W'($urandom_range(1, 15));
      hold = $urandom_range(1, 7);
      edges(hold);
    end

    edges(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
